// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings and
// the baud divider computation used by both the RX and TX paths.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 10_000_000;
    localparam int unsigned DEFAULT_BAUD   = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clk cycles per oversample tick; never below 1.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned denom;
        int unsigned div;
        denom = baud * oversample;
        div   = (clk_hz + denom / 2) / denom;
        return (div == 0) ? 1 : div;
    endfunction

    // Counter width able to hold 0..n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks; clear realigns
// the count so the next tick lands DIV cycles after the clear.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    W    = cnt_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, one-entry valid/ready
// holding buffer with framing-error and overrun pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = cnt_width(OVERSAMPLE);
    localparam int unsigned BW  = cnt_width(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    logic                 sync_meta;
    logic                 sync_line;
    logic                 line_prev;
    logic [1:0]           sync_age;
    logic                 armed;
    logic                 start_edge;
    logic                 tick;

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    // The synchronizer resets to idle-high, so its first two outputs are not
    // the real line; edges are only armed once a genuine high has been seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
            sync_age  <= '0;
            armed     <= 1'b0;
        end else begin
            sync_meta <= uart_rxd;
            sync_line <= sync_meta;
            line_prev <= sync_line;
            if (sync_age != 2'd2) begin
                sync_age <= sync_age + 2'd1;
            end
            if (sync_age == 2'd2 && sync_line) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = (state == IDLE) && armed && line_prev && !sync_line;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_edge),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            state    <= sync_line ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {sync_line, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + BW'(1);
                            if (bit_cnt == BITS_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (sync_line) begin
                                state <= IDLE;
                                // A same-cycle accept frees the buffer for the new byte.
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                            end else begin
                                rx_frame_err <= 1'b1;
                                state        <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                BREAK: begin
                    if (sync_line) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at 16 clk per bit (DIV=1).
module tb_uart_rx_frame;

    localparam int unsigned BIT_CLKS   = 16;
    localparam int unsigned FRAME_CLKS = 10 * BIT_CLKS;
    localparam int          STOP_SAMPLE = 155;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  got_q[$];
    int          valid_cycles = 0;
    int          fe_cycles    = 0;
    int          ov_cycles    = 0;
    int          busy_cycles  = 0;
    int unsigned cyc_cnt      = 0;
    int unsigned valid_rise   = 0;
    logic        valid_prev   = 1'b0;

    uart_rx_frame #(
        .CLK_HZ     (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && !valid_prev) valid_rise = cyc_cnt;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_frame_err) fe_cycles++;
            if (rx_overrun) ov_cycles++;
            if (rx_busy) busy_cycles++;
        end
        valid_prev = rx_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line level c clocks into a frame: start, 8 data bits LSB first, stop.
    function automatic logic line_bit(input logic [7:0] d, input logic stop_ok, input int c);
        if (c < BIT_CLKS) return 1'b0;
        if (c < 9 * BIT_CLKS) return d[(c - BIT_CLKS) / BIT_CLKS];
        return stop_ok;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input int ready_at, input int extra_low);
        for (int c = 0; c < int'(FRAME_CLKS); c++) begin
            uart_rxd = line_bit(d, stop_ok, c);
            if (ready_at >= 0 && c == ready_at) rx_ready = 1'b1;
            if (ready_at >= 0 && c == ready_at + 1) rx_ready = 1'b0;
            cyc(1);
        end
        if (!stop_ok) begin
            uart_rxd = 1'b0;
            cyc(extra_low);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        cyc(3);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", rx_frame_err, rx_overrun); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        reset = 1'b0;
        cyc(6);
    endtask

    task automatic test_basic;
        int b0, v0, f0, o0, bz0;
        int unsigned t0;
        rx_ready = 1'b1;
        b0 = got_q.size(); v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles; bz0 = busy_cycles;
        t0 = cyc_cnt;
        send_frame(8'hA5, 1'b1, -1, 0);
        cyc(10);
        checks++; if (got_q.size() - b0 != 1) begin failures++; $display("FAIL basic_count: got %0d bytes want 1", got_q.size() - b0); end
        else begin
            checks++; if (got_q[b0] !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h want a5", got_q[b0]); end
        end
        checks++; if (valid_cycles - v0 != 1) begin failures++; $display("FAIL basic_valid_width: got %0d cycles want 1", valid_cycles - v0); end
        checks++; if (fe_cycles != f0 || ov_cycles != o0) begin failures++; $display("FAIL basic_flags: got fe=%0d ov=%0d want 0 0", fe_cycles - f0, ov_cycles - o0); end
        checks++; if (valid_rise - t0 < 150 || valid_rise - t0 > 160) begin failures++; $display("FAIL basic_latency: got %0d clk want 150..160", valid_rise - t0); end
        checks++; if (busy_cycles - bz0 < 148 || busy_cycles - bz0 > 156) begin failures++; $display("FAIL basic_busy_len: got %0d clk want 148..156", busy_cycles - bz0); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b want 0", rx_busy); end
    endtask

    task automatic test_glitch;
        int b0, f0, bz0;
        b0 = got_q.size(); f0 = fe_cycles; bz0 = busy_cycles;
        uart_rxd = 1'b0;
        cyc(4);
        uart_rxd = 1'b1;
        cyc(12);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
        checks++; if (busy_cycles - bz0 < 1 || busy_cycles - bz0 > 10) begin failures++; $display("FAIL glitch_busy_len: got %0d clk want 1..10", busy_cycles - bz0); end
        cyc(170);
        checks++; if (got_q.size() != b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_no_byte: got %0d bytes valid=%b want 0 0", got_q.size() - b0, rx_valid); end
        checks++; if (fe_cycles != f0) begin failures++; $display("FAIL glitch_no_err: got %0d want 0", fe_cycles - f0); end
    endtask

    task automatic test_frame_err;
        int b0, f0, o0;
        rx_ready = 1'b1;
        b0 = got_q.size(); f0 = fe_cycles; o0 = ov_cycles;
        send_frame(8'h3C, 1'b0, -1, 40);
        cyc(20);
        checks++; if (fe_cycles - f0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cycles - f0); end
        checks++; if (got_q.size() != b0) begin failures++; $display("FAIL ferr_no_byte: got %0d bytes want 0", got_q.size() - b0); end
        send_frame(8'h55, 1'b1, -1, 0);
        cyc(10);
        checks++; if (got_q.size() - b0 != 1) begin failures++; $display("FAIL ferr_recover_count: got %0d want 1", got_q.size() - b0); end
        else begin
            checks++; if (got_q[b0] !== 8'h55) begin failures++; $display("FAIL ferr_recover_data: got %h want 55", got_q[b0]); end
        end
        checks++; if (fe_cycles - f0 != 1 || ov_cycles != o0) begin failures++; $display("FAIL ferr_flags: got fe=%0d ov=%0d want 1 0", fe_cycles - f0, ov_cycles - o0); end
    endtask

    task automatic test_overrun;
        int b0, o0;
        rx_ready = 1'b0;
        b0 = got_q.size(); o0 = ov_cycles;
        send_frame(8'h11, 1'b1, -1, 0);
        cyc(5);
        send_frame(8'h22, 1'b1, -1, 0);
        cyc(5);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin failures++; $display("FAIL ovr_hold: got valid=%b data=%h want 1 11", rx_valid, rx_data); end
        checks++; if (ov_cycles - o0 != 1) begin failures++; $display("FAIL ovr_pulse: got %0d cycles want 1", ov_cycles - o0); end
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_valid: got %b want 0", rx_valid); end
        checks++; if (got_q.size() - b0 != 1 || got_q[got_q.size() - 1] !== 8'h11) begin failures++; $display("FAIL ovr_accept_data: got %0d bytes last=%h want 1 11", got_q.size() - b0, got_q[got_q.size() - 1]); end
        cyc(5);
    endtask

    task automatic test_simul_accept;
        int b0, o0, v0;
        rx_ready = 1'b0;
        send_frame(8'h66, 1'b1, -1, 0);
        cyc(5);
        b0 = got_q.size(); o0 = ov_cycles; v0 = valid_cycles;
        send_frame(8'h77, 1'b1, STOP_SAMPLE - 1, 0);
        checks++; if (got_q.size() - b0 != 1 || got_q[b0] !== 8'h66) begin failures++; $display("FAIL simul_old: got %0d bytes first=%h want 1 66", got_q.size() - b0, got_q[b0]); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin failures++; $display("FAIL simul_new: got valid=%b data=%h want 1 77", rx_valid, rx_data); end
        checks++; if (ov_cycles != o0) begin failures++; $display("FAIL simul_overrun: got %0d want 0", ov_cycles - o0); end
        checks++; if (valid_cycles - v0 != int'(FRAME_CLKS)) begin failures++; $display("FAIL simul_valid_gap: got %0d cycles want %0d", valid_cycles - v0, FRAME_CLKS); end
        rx_ready = 1'b1;
        cyc(1);
        checks++; if (got_q.size() - b0 != 2 || got_q[b0 + 1] !== 8'h77) begin failures++; $display("FAIL simul_drain: got %0d bytes want 2 ending 77", got_q.size() - b0); end
        cyc(5);
    endtask

    task automatic test_reset_mid;
        int b0, f0;
        rx_ready = 1'b0;
        send_frame(8'h9A, 1'b1, -1, 0);
        cyc(5);
        for (int c = 0; c < 60; c++) begin
            uart_rxd = line_bit(8'hF0, 1'b1, c);
            cyc(1);
        end
        checks++; if (rx_busy !== 1'b1 || rx_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre: got busy=%b valid=%b want 1 1", rx_busy, rx_valid); end
        reset = 1'b1;
        cyc(1);
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_busy !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            failures++; $display("FAIL rmid_outputs: got valid=%b data=%h busy=%b fe=%b ov=%b want all 0", rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun);
        end
        reset = 1'b0;
        rx_ready = 1'b1;
        b0 = got_q.size(); f0 = fe_cycles;
        for (int c = 61; c < int'(FRAME_CLKS); c++) begin
            uart_rxd = line_bit(8'hF0, 1'b1, c);
            cyc(1);
        end
        uart_rxd = 1'b1;
        cyc(20);
        checks++; if (got_q.size() != b0 || fe_cycles != f0) begin failures++; $display("FAIL rmid_tail: got %0d bytes fe=%0d want 0 0", got_q.size() - b0, fe_cycles - f0); end
        send_frame(8'h0F, 1'b1, -1, 0);
        cyc(10);
        checks++; if (got_q.size() - b0 != 1 || got_q[b0] !== 8'h0F) begin failures++; $display("FAIL rmid_next: got %0d bytes first=%h want 1 0f", got_q.size() - b0, got_q[b0]); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic       ok;
        int         b0, f0, o0, nbad;
        rx_ready = 1'b1;
        b0 = got_q.size(); f0 = fe_cycles; o0 = ov_cycles;
        nbad = 0;
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom_range(0, 255));
            ok = (i == 3) ? 1'b0 : ($urandom_range(0, 4) != 0);
            send_frame(d, ok, -1, 0);
            if (ok) exp_q.push_back(d);
            else nbad++;
            cyc($urandom_range(4, 20));
        end
        cyc(10);
        checks++; if (got_q.size() - b0 != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d bytes want %0d", got_q.size() - b0, exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++; if (got_q[b0 + i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[b0 + i], exp_q[i]); end
            end
        end
        checks++; if (fe_cycles - f0 != nbad) begin failures++; $display("FAIL rand_ferr: got %0d want %0d", fe_cycles - f0, nbad); end
        checks++; if (ov_cycles != o0) begin failures++; $display("FAIL rand_overrun: got %0d want 0", ov_cycles - o0); end
    endtask

    initial begin
        reset    = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_simul_accept;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
